// File: rtl/cdb_complete_stage_if.sv
// FU-to-CDB completion bus: per-FU requests and packets in,
// per-FU hazard mask and registered CDB broadcast slots out.
interface cdb_complete_stage_if #(
  parameter int NUM_FU = 8,
  parameter int CDB_W  = 3,
  parameter int PKT_W  = 64
);
  logic [NUM_FU-1:0]       fu_done;
  logic [NUM_FU*PKT_W-1:0] fu_pkt;
  logic [NUM_FU-1:0]       fu_hazard;
  logic [CDB_W-1:0]        cdb_valid;
  logic [CDB_W*PKT_W-1:0]  cdb_pkt;

  // Execution side: presents completions, consumes stalls and broadcasts.
  modport master (
    output fu_done, fu_pkt,
    input  fu_hazard, cdb_valid, cdb_pkt
  );

  // Completion stage side.
  modport slave (
    input  fu_done, fu_pkt,
    output fu_hazard, cdb_valid, cdb_pkt
  );
endinterface

// File: rtl/cdb_complete_stage.sv
// Completion stage: round-robin arbitration of FU completions onto CDB_W
// broadcast slots, registered CDB outputs, per-FU stall mask, and two
// saturating performance counters.
module cdb_complete_stage #(
  parameter int NUM_FU = 8,
  parameter int CDB_W  = 3,
  parameter int PKT_W  = 64,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     squash,
  cdb_complete_stage_if.slave      bus,
  output logic [CNT_W-1:0]         stall_cycles,
  output logic [CNT_W-1:0]         full_cycles
);
  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int NG_W  = $clog2(CDB_W + 1);

  logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [CDB_W-1:0]       cdb_valid_q, cdb_valid_d;
  logic [CDB_W*PKT_W-1:0] cdb_pkt_q, cdb_pkt_d;
  logic [CNT_W-1:0]       stall_cycles_q, stall_cycles_d;
  logic [CNT_W-1:0]       full_cycles_q, full_cycles_d;

  logic [NUM_FU-1:0] grant;
  logic [PTR_W-1:0]  slot_sel [CDB_W];
  logic [CDB_W-1:0]  slot_used;
  logic [NG_W-1:0]   n_grant;
  logic [PTR_W-1:0]  last_idx;
  logic [PTR_W-1:0]  scan_idx;
  logic [NUM_FU-1:0] hazard;

  // Round-robin scan from rr_ptr: the first CDB_W requesters win, in scan order.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    grant     = '0;
    slot_used = '0;
    n_grant   = '0;
    last_idx  = rr_ptr_q;
    scan_idx  = '0;
    for (int k = 0; k < CDB_W; k++) slot_sel[k] = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      scan_idx = PTR_W'((int'(rr_ptr_q) + k) % NUM_FU);
      if (bus.fu_done[scan_idx] && (n_grant < NG_W'(CDB_W))) begin
        grant[scan_idx]    = 1'b1;
        slot_sel[n_grant]  = scan_idx;
        slot_used[n_grant] = 1'b1;
        last_idx           = scan_idx;
        n_grant            = n_grant + 1'b1;
      end
    end
  end

  // Stall mask: requesters that lost arbitration; suppressed on flush or reset.
  always_comb begin
    hazard = bus.fu_done & ~grant;
    if (rst || squash) hazard = '0;
  end

  // Next-state for CDB slots, round-robin pointer and counters.
  always_comb begin
    cdb_valid_d    = slot_used;
    cdb_pkt_d      = cdb_pkt_q;
    rr_ptr_d       = rr_ptr_q;
    stall_cycles_d = stall_cycles_q;
    full_cycles_d  = full_cycles_q;
    for (int k = 0; k < CDB_W; k++) begin
      if (slot_used[k]) cdb_pkt_d[k*PKT_W +: PKT_W] = bus.fu_pkt[int'(slot_sel[k])*PKT_W +: PKT_W];
    end
    if (n_grant != '0) rr_ptr_d = PTR_W'((int'(last_idx) + 1) % NUM_FU);
    if ((|hazard) && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + 1'b1;
    if ((n_grant == NG_W'(CDB_W)) && (full_cycles_q != '1)) full_cycles_d = full_cycles_q + 1'b1;
    if (squash) begin
      // Flushed work never reaches the CDB and is not counted.
      cdb_valid_d    = '0;
      cdb_pkt_d      = cdb_pkt_q;
      rr_ptr_d       = '0;
      stall_cycles_d = stall_cycles_q;
      full_cycles_d  = full_cycles_q;
    end
  end

  // State registers with synchronous reset; reset wins over squash.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      rr_ptr_q       <= '0;
      cdb_valid_q    <= '0;
      cdb_pkt_q      <= '0;
      stall_cycles_q <= '0;
      full_cycles_q  <= '0;
    end else begin
      rr_ptr_q       <= rr_ptr_d;
      cdb_valid_q    <= cdb_valid_d;
      cdb_pkt_q      <= cdb_pkt_d;
      stall_cycles_q <= stall_cycles_d;
      full_cycles_q  <= full_cycles_d;
    end
  end

  assign bus.fu_hazard = hazard;
  assign bus.cdb_valid = cdb_valid_q;
  assign bus.cdb_pkt   = cdb_pkt_q;
  assign stall_cycles  = stall_cycles_q;
  assign full_cycles   = full_cycles_q;
endmodule

// File: doc/cdb_complete_stage.md
Name: cdb_complete_stage

Overview:
- Sits directly downstream of the execution stage.
- Accepts one completion request plus packet per functional unit each cycle and grants up to CDB_W of them onto the common data bus (CDB) using round-robin priority.
- Registers the granted packets for broadcast to the ROB, RS wakeup and map table.
- Returns a per-FU hazard (stall) mask so ungranted FUs hold their result.

Parameters:
- NUM_FU, 8, number of FUs; index order ALU_1, ALU_2, ALU_3, MULT_1, MULT_2, LS_1, LS_2, BRANCH (0..7).
- CDB_W, 3, CDB broadcast slots per cycle; 1 <= CDB_W <= NUM_FU.
- PKT_W, 64, width of one opaque FU completion packet.
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- fu_done  in  NUM_FU  completion request per FU; bit i corresponds to FU index i.
- fu_pkt  in  NUM_FU*PKT_W  completion packets; packet i occupies bits [i*PKT_W +: PKT_W].
- squash  in  1  pipeline flush from retire (branch mispredict).
- fu_hazard  out  NUM_FU  combinational stall mask back to the FUs; bit i = 1 means FU i must hold.
- cdb_valid  out  CDB_W  registered valid per CDB slot.
- cdb_pkt  out  CDB_W*PKT_W  registered packets; slot k occupies bits [k*PKT_W +: PKT_W].
- stall_cycles  out  CNT_W  count of cycles with at least one hazard bit set; saturating.
- full_cycles  out  CNT_W  count of cycles in which all CDB_W slots were granted; saturating.

Behaviour:
- State:
  - rr_ptr: log2(NUM_FU) bits.
  - cdb_valid / cdb_pkt registers.
  - Two performance counters.
- Arbitration (combinational, same cycle as fu_done):
  - Scan FU indices rr_ptr, rr_ptr+1, ... modulo NUM_FU.
  - Grant the first min(CDB_W, popcount(fu_done)) requesters found.
  - Slot k receives the (k+1)-th granted FU in scan order.
- fu_hazard[i] = fu_done[i] & ~grant[i]. An FU with fu_done low never sees hazard.
- Handshake:
  - A granted FU may present a new packet the next cycle.
  - A stalled FU holds fu_done and fu_pkt stable until granted.
  - The block does not check packet stability.
- Latency: a packet granted in cycle N appears on cdb_pkt with cdb_valid=1 in cycle N+1, valid for exactly one cycle.
- Unused slots: cdb_valid=0; cdb_pkt holds its previous value (don't-care).
- rr_ptr update:
  - If any grant is made, rr_ptr <= (last granted index + 1) mod NUM_FU.
  - Otherwise rr_ptr is unchanged.
  - Wrap from 7 to 0 is required.
- squash, sampled in cycle N:
  - fu_hazard = 0 in cycle N, since the FUs flush themselves.
  - No grants are registered; cdb_valid = 0 in N+1.
  - rr_ptr <= 0.
  - Counters do not increment in cycle N.
- squash with rst: rst dominates; the end state is identical.
- Reset, sampled at a rising edge:
  - cdb_valid=0, cdb_pkt=0, rr_ptr=0, stall_cycles=0, full_cycles=0.
  - While rst is high, fu_hazard=0.
  - Reset mid-operation discards any in-flight CDB slots.
- Counters:
  - Increment by 1 on the qualifying cycle.
  - Saturate at 2^CNT_W-1; no wrap.
- No grant ever goes to an FU with fu_done=0.
- At most one slot per FU per cycle.
- Grants never exceed CDB_W.

Test Plan:
- Reset: hold rst 2 cycles with fu_done=8'hFF -> fu_hazard=0, cdb_valid=0, both counters 0, rr_ptr=0.
- Light load: rr_ptr=0, fu_done=8'b0000_0101 -> next cycle cdb_valid=3'b011, slot0=pkt[0], slot1=pkt[2]; fu_hazard=0; rr_ptr=3.
- Oversubscribed: rr_ptr=0, fu_done=8'hFF held -> cycle1 grants 0,1,2 with fu_hazard=8'hF8; cycle2 grants 3,4,5 with fu_hazard=8'hC7; cycle3 grants 6,7,0 (wrap) with rr_ptr=1; full_cycles=3, stall_cycles=3.
- Wrap fairness: rr_ptr=6, fu_done=8'b1100_0011 -> slots carry FU6, FU7, FU0 in that order; fu_hazard=8'b0000_0010; rr_ptr=1.
- Squash: fu_done=8'hFF with squash=1 -> fu_hazard=0 that cycle, cdb_valid=0 next cycle, rr_ptr=0, counters unchanged.
- Saturation (CNT_W=4 build): 20 consecutive oversubscribed cycles -> stall_cycles=15 and full_cycles=15, no wrap to 0.
